// File: rtl/booth_control.sv
// -----------------------------------------------------------------------------
// booth_control
//   Sequencer for a 4x4 radix-2 Booth multiplier datapath (A, Q, Q-1, M and a
//   4-bit add/sub unit). It issues load / add-sub / shift strobes, counts the
//   iterations and runs a start/busy/done handshake with the host. It holds no
//   data bits.
//
//   Optional build macro: BOOTH_SKIP_EN
//     When defined, an ARITH cycle with q0==q_1 shifts directly (sh=1) and
//     counts the iteration, so no-op iterations take one cycle instead of two.
//
// Parameters
//   N   iteration count (multiplier width)
//   CW  iteration counter width, 2^CW > N
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset
//   start  in   start request, sampled only in IDLE
//   q0     in   Q[0] from the datapath
//   q_1    in   Q-1 bit from the datapath
//   ld_m   out  load M from the external multiplicand
//   ld_q   out  load Q from the external multiplier
//   clr_a  out  clear A and Q-1 on load
//   ld_a   out  load A from the add/sub output
//   resta  out  add/sub mode: 1 = A-M, 0 = A+M
//   sh     out  arithmetic right shift of {A,Q,Q-1}
//   busy   out  high from LOAD through the last shift
//   done   out  one-cycle pulse, product {A,Q} valid
//   iter   out  iterations remaining (debug)
// -----------------------------------------------------------------------------
module booth_control #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          q0,
  input  logic          q_1,
  output logic          ld_m,
  output logic          ld_q,
  output logic          clr_a,
  output logic          ld_a,
  output logic          resta,
  output logic          sh,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARITH,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LP_N   = CW'(N);
  localparam logic [CW-1:0] LP_ONE = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_iter;
  logic          r_load;
  logic          r_sh;
  logic          r_busy;
  logic          r_done;

  logic          w_arith;
  logic          w_op;
  logic          w_skip;

  assign w_arith = (r_state == S_ARITH);
  // Booth pair 01 or 10 needs an add/sub; 00 and 11 are pure shifts.
  assign w_op    = q0 ^ q_1;

`ifdef BOOTH_SKIP_EN
  assign w_skip = w_arith & ~w_op;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_load  <= 1'b0;
      r_sh    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Strobes are single-cycle; each transition below re-asserts what the
      // next state needs.
      r_load <= 1'b0;
      r_sh   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_ARITH;
          r_iter  <= LP_N;
        end
        S_ARITH: begin
          if (w_skip) begin
            // Shift happens in this cycle (sh driven from w_skip).
            if (r_iter != '0) begin
              r_iter <= r_iter - LP_ONE;
            end
            if (r_iter == LP_ONE) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= S_SHIFT;
            r_sh    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_iter != '0) begin
            r_iter <= r_iter - LP_ONE;
          end
          if (r_iter == LP_ONE) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ARITH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_m  = r_load;
  assign ld_q  = r_load;
  assign clr_a = r_load;
  // ld_a/resta follow the datapath bits combinationally during ARITH.
  assign ld_a  = w_arith & w_op;
  assign resta = w_arith & w_op & q0;
  assign sh    = r_sh | w_skip;
  assign busy  = r_busy;
  assign done  = r_done;
  assign iter  = r_iter;

endmodule

// File: tb/tb_booth_control.sv
`timescale 1ns/1ps
module tb_booth_control;

  localparam int N  = 4;
  localparam int CW = 3;

`ifdef BOOTH_SKIP_EN
  localparam bit SKIP      = 1'b1;
  localparam int EXP_LAT   = 8;
  localparam int EXP_BUSY  = 7;
  localparam int EXP_PER   = 9;
`else
  localparam bit SKIP      = 1'b0;
  localparam int EXP_LAT   = 10;
  localparam int EXP_BUSY  = 9;
  localparam int EXP_PER   = 11;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic q0, q_1;
  logic ld_m, ld_q, clr_a, ld_a, resta, sh, busy, done;
  logic [CW-1:0] iter;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_control #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .q_1(q_1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .ld_a(ld_a), .resta(resta),
    .sh(sh), .busy(busy), .done(done), .iter(iter)
  );

  // ---------------- Booth datapath model ----------------
  // A carries one guard bit so that -8 x -8 yields +64 in {A,Q}.
  logic [3:0] mcand_in = 4'd0;
  logic [3:0] mplier_in = 4'd0;
  logic [4:0] a_reg = 5'd0;
  logic [3:0] q_reg = 4'd0;
  logic [3:0] m_reg = 4'd0;
  logic       qm1_reg = 1'b0;
  logic [7:0] product;

  assign q0      = q_reg[0];
  assign q_1     = qm1_reg;
  assign product = {a_reg[3:0], q_reg};

  always @(posedge clk) begin
    if (ld_m) m_reg <= mcand_in;
    if (ld_q) q_reg <= mplier_in;
    if (clr_a) begin
      a_reg   <= 5'd0;
      qm1_reg <= 1'b0;
    end
    if (ld_a) a_reg <= resta ? a_reg - {m_reg[3], m_reg} : a_reg + {m_reg[3], m_reg};
    if (sh) begin
      a_reg   <= {a_reg[4], a_reg[4:1]};
      q_reg   <= {a_reg[0], q_reg[3:1]};
      qm1_reg <= q_reg[0];
    end
  end

  // ---------------- Reference schedule model ----------------
  typedef struct packed {
    logic          ld;
    logic          lda;
    logic          rsa;
    logic          shf;
    logic          bsy;
    logic          dne;
    logic [CW-1:0] itr;
  } exp_t;

  exp_t sched[$];
  exp_t drop;
  logic [7:0] exp_prod = 8'd0;

  // Whole-operation expectation derived from the multiplier's bit pairs.
  function automatic void push_run(input logic [3:0] mq);
    exp_t e;
    logic prev, cur;
    e = '0; e.ld = 1'b1; e.bsy = 1'b1;
    sched.push_back(e);
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      cur = mq[i];
      e = '0; e.bsy = 1'b1; e.itr = CW'(N - i);
      if (SKIP && cur == prev) begin
        e.shf = 1'b1;
        sched.push_back(e);
      end else begin
        e.lda = (cur != prev);
        e.rsa = (cur != prev) & cur;
        sched.push_back(e);
        e.lda = 1'b0; e.rsa = 1'b0; e.shf = 1'b1;
        sched.push_back(e);
      end
      prev = cur;
    end
    e = '0; e.dne = 1'b1;
    sched.push_back(e);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      sched.delete();
    end else if (sched.size() != 0) begin
      drop = sched.pop_front();
    end else if (start) begin
      push_run(mplier_in);
      exp_prod = $signed({{4{mcand_in[3]}}, mcand_in}) * $signed({{4{mplier_in[3]}}, mplier_in});
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t e;
    logic [CW+7:0] act_v, exp_v;
    if (armed) begin
      e = (sched.size() != 0) ? sched[0] : '0;
      act_v = {ld_m, ld_q, clr_a, ld_a, resta, sh, busy, done, iter};
      exp_v = {e.ld, e.ld, e.ld, e.lda, e.rsa, e.shf, e.bsy, e.dne, e.itr};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cyc %0d ctrl_outputs: got %h expected %h", cyc, act_v, exp_v);
      end
      tests++;
      if (ld_a && sh) begin
        fails++;
        $display("FAIL cyc %0d ld_a_sh_exclusive: got ld_a=%b sh=%b required not both 1", cyc, ld_a, sh);
      end
      if (e.dne) begin
        tests++;
        if (product !== exp_prod) begin
          fails++;
          $display("FAIL cyc %0d product_model: got %h expected %h", cyc, product, exp_prod);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("[TB] %s ok: %0d", name, act);
    end
  endtask

  // Start one operation from IDLE and follow it to done.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                        output int lat, output int busy_cnt, output int resta_cnt,
                        output logic [7:0] prod);
    mcand_in = m;
    mplier_in = q;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_cnt = 0; resta_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (ld_a && resta) resta_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL run_timeout: got no done after %0d cycles expected done", lat);
    end
    prod = product;
    $display("[TB] op M=%h Q=%h -> {A,Q}=%h lat=%0d busy=%0d resta=%0d", m, q, prod, lat, busy_cnt, resta_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, bcnt, rcnt, dcnt, cnt, last_done, ok_per;
    logic [7:0] prod;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;
    chk("reset_outputs", int'({ld_m, ld_q, clr_a, ld_a, resta, sh, busy, done, iter}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 3 x 6
    run_op(4'b0011, 4'b0110, lat, bcnt, rcnt, prod);
    chk("p_3x6", int'(prod), 8'h12);
    chk("lat_3x6", lat, EXP_LAT);
    chk("busy_3x6", bcnt, EXP_BUSY);

    // -3 x 2
    run_op(4'b1101, 4'b0010, lat, bcnt, rcnt, prod);
    chk("p_m3x2", int'(prod), 8'hFA);
    chk("resta_m3x2", rcnt, 1);

    // -8 x -8
    run_op(4'b1000, 4'b1000, lat, bcnt, rcnt, prod);
    chk("p_m8xm8", int'(prod), 8'h40);
    repeat (3) @(posedge clk);
    #1;
    chk("p_hold_idle", int'(product), 8'h40);

    // start pulsed again during ARITH
    mcand_in = 4'b0011; mplier_in = 4'b0110;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;       // LOAD
    @(posedge clk); #1; start = 1'b1;       // ARITH
    @(posedge clk); #1; start = 1'b0;
    dcnt = 0;
    prod = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        dcnt++;
        prod = product;
      end
      @(posedge clk); #1;
    end
    chk("ignored_start_dones", dcnt, 1);
    chk("ignored_start_prod", int'(prod), 8'h12);

    // reset during third shift
    mcand_in = 4'b0011; mplier_in = 4'b0110;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin
      if (sh) cnt++;
      if (cnt < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("third_shift_seen", cnt, 3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_outputs", int'({ld_m, ld_q, clr_a, ld_a, resta, sh, busy, done, iter}), 0);
    reset = 1'b1;
    run_op(4'b0010, 4'b0011, lat, bcnt, rcnt, prod);
    chk("p_2x3_after_reset", int'(prod), 8'h06);

    // start held high: back-to-back operations
    mcand_in = 4'b0011; mplier_in = 4'b0110;
    start = 1'b1;
    dcnt = 0; last_done = -1; ok_per = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 29) start = 1'b0;
      if (done) begin
        if (last_done >= 0 && (i - last_done) != EXP_PER) begin
          ok_per = 0;
          $display("[TB] b2b done spacing %0d", i - last_done);
        end
        last_done = i;
        dcnt++;
        $display("[TB] b2b done at %0d product %h", i, product);
      end
    end
    chk("b2b_dones_ge2", int'(dcnt >= 2), 1);
    chk("b2b_period", ok_per, 1);
    chk("b2b_final_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
